spi_xfer_scheduler: RTL and testbench

- Shares the single SPI master core between NREQ on-chip requesters.
- Each requester hands over one 8-bit frame. The block arbitrates round-robin, loads the frame, issues a one-cycle send_data strobe to the core, then waits for the core's receive_data pulse.
- It returns the captured MISO byte and a completion acknowledge to the granted requester.
- Sits between requester logic and the SPI slave-select/shift-register datapath. It also enforces a minimum idle gap between frames and a transfer timeout.

---
 rtl/spi_sched_pkg.sv | 23 ++
 rtl/spi_rr_arbiter.sv | 29 ++
 rtl/spi_xfer_scheduler.sv | 134 +++++++++++++
 tb/tb_spi_xfer_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI transfer scheduler: FSM encoding and default timing constants.
package spi_sched_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARB      = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_WAIT_RCV = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        ARB      = ST_ARB,
        LOAD     = ST_LOAD,
        WAIT_RCV = ST_WAIT_RCV,
        DONE     = ST_DONE,
        GAP      = ST_GAP
    } state_t;

    localparam int          DEF_GAP_CYCLES     = 4;
    localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd4096;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NREQ.
module spi_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   next_ptr,
    output logic            any
);

    // Outer loop is the scan distance from ptr, inner loop finds the requester at that distance.
    always_comb begin
        win      = '0;
        next_ptr = ptr;
        any      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && req[i] && ((int'(ptr) + k == i) || (int'(ptr) + k == i + NREQ))) begin
                    any      = 1'b1;
                    win[i]   = 1'b1;
                    next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one SPI master core among NREQ requesters: round-robin grant, send strobe,
// receive/abort/timeout handling, completion ack and an enforced inter-frame gap.
module spi_xfer_scheduler
    import spi_sched_pkg::*;
#(
    parameter int          NREQ           = 4,
    parameter int          GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic              core_ready,
    input  logic              tip,
    input  logic              receive_data,
    input  logic [7:0]        miso_byte,
    output logic              send_data,
    output logic [7:0]        mosi_byte,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rx_data,
    output logic              err,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYCLES);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [15:0]     tcnt;
    logic [GW-1:0]   gcnt;
    logic [NREQ-1:0] win;
    logic [PW-1:0]   next_ptr;
    logic            any;
    logic [7:0]      win_data;

    spi_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req      (req),
        .ptr      (ptr),
        .win      (win),
        .next_ptr (next_ptr),
        .any      (any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (win[i]) win_data = req_data[8*i +: 8];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            ptr       <= '0;
            tcnt      <= '0;
            gcnt      <= '0;
            send_data <= 1'b0;
            mosi_byte <= '0;
            grant     <= '0;
            ack       <= '0;
            rx_data   <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            send_data <= 1'b0;
            ack       <= '0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    // A transfer already in flight on the core (tip) must finish before we claim it.
                    if (core_ready && |req && !tip) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (any) begin
                        grant     <= win;
                        mosi_byte <= win_data;
                        ptr       <= next_ptr;
                        send_data <= 1'b1;
                        state     <= LOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    tcnt  <= '0;
                    state <= WAIT_RCV;
                end
                WAIT_RCV: begin
                    tcnt <= tcnt + 16'd1;
                    if (receive_data) begin
                        rx_data <= miso_byte;
                        ack     <= grant;
                        state   <= DONE;
                    // Abort when the core leaves active mode, or as the count steps onto TIMEOUT-1.
                    end else if (!core_ready || (tcnt == TIMEOUT_CYCLES - 16'd2)) begin
                        rx_data <= '0;
                        ack     <= grant;
                        err     <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    grant <= '0;
                    gcnt  <= GAP_LD;
                    if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    gcnt <= gcnt - GW'(1);
                    if (gcnt == GW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench for spi_xfer_scheduler; a second instance with a short timeout covers the abort-by-timeout path.
module tb_spi_xfer_scheduler;

    localparam int NREQ = 4;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic              core_ready, tip, receive_data;
    logic [7:0]        miso_byte;

    logic              send_data, err, busy;
    logic [7:0]        mosi_byte, rx_data;
    logic [NREQ-1:0]   grant, ack;

    logic              b_send_data, b_err, b_busy;
    logic [7:0]        b_mosi_byte, b_rx_data;
    logic [NREQ-1:0]   b_grant, b_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    spi_xfer_scheduler #(.NREQ(NREQ), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16'd4096)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_data(req_data),
        .core_ready(core_ready), .tip(tip), .receive_data(receive_data), .miso_byte(miso_byte),
        .send_data(send_data), .mosi_byte(mosi_byte), .grant(grant), .ack(ack),
        .rx_data(rx_data), .err(err), .busy(busy)
    );

    spi_xfer_scheduler #(.NREQ(NREQ), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16'd16)) dut_t (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_data(req_data),
        .core_ready(core_ready), .tip(tip), .receive_data(receive_data), .miso_byte(miso_byte),
        .send_data(b_send_data), .mosi_byte(b_mosi_byte), .grant(b_grant), .ack(b_ack),
        .rx_data(b_rx_data), .err(b_err), .busy(b_busy)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESET = 1'b1; req = '0; req_data = '0; core_ready = 1'b1; tip = 1'b0;
        receive_data = 1'b0; miso_byte = '0;
        tick(); tick();
        PRESET = 1'b0;
        tick();
    endtask

    // Ticks until the selected instance strobes send_data; n = ticks taken, or -1 if the bound expired.
    task automatic wait_send(input bit use_b, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(use_b ? b_send_data : send_data) && n < 60);
        if (!(use_b ? b_send_data : send_data)) n = -1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1; req = '0; req_data = '0; core_ready = 1'b0; tip = 1'b0;
        receive_data = 1'b0; miso_byte = '0;
        tick();
        n_checks++;
        if ({send_data, mosi_byte, grant, ack, rx_data, err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {send_data, mosi_byte, grant, ack, rx_data, err, busy});
        end
        PRESET = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b grant=%b required 0/0000", busy, grant);
        end
    endtask

    task automatic test_single();
        int extra;
        do_reset();
        req[2] = 1'b1; req_data[8*2 +: 8] = 8'hA5;
        tick();
        n_checks++;
        if (send_data !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_arb: send=%b busy=%b required 0/1", send_data, busy);
        end
        tick();
        n_checks++;
        if (send_data !== 1'b1 || mosi_byte !== 8'hA5 || grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_load: send=%b mosi=%h grant=%b required 1/a5/0100", send_data, mosi_byte, grant);
        end
        extra = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (send_data !== 1'b0 || ack !== '0 || mosi_byte !== 8'hA5) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL single_wait: %0d bad cycles while waiting, required 0", extra);
        end
        receive_data = 1'b1; miso_byte = 8'h3C;
        tick();
        receive_data = 1'b0; req[2] = 1'b0;
        n_checks++;
        if (ack !== 4'b0100 || rx_data !== 8'h3C || err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: ack=%b rx=%h err=%b required 0100/3c/0", ack, rx_data, err);
        end
        tick();
        n_checks++;
        if (grant !== '0 || ack !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gap: grant=%b ack=%b busy=%b required 0000/0000/1", grant, ack, busy);
        end
        tick(); tick(); tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gap_end: busy=%b required 1", busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_fairness();
        int n;
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            wait_send(1'b0, n);
            n_checks++;
            if (n != ((k == 0) ? 2 : 7)) begin
                n_fail++;
                $display("FAIL fair_spacing[%0d]: %0d cycles to send, required %0d", k, n, (k == 0) ? 2 : 7);
            end
            n_checks++;
            if (grant !== exp_g || mosi_byte !== (8'h10 + 8'(k % 4))) begin
                n_fail++;
                $display("FAIL fair_grant[%0d]: grant=%b mosi=%h required %b/%h", k, grant, mosi_byte, exp_g, 8'h10 + 8'(k % 4));
            end
            tick();
            receive_data = 1'b1; miso_byte = 8'h80 + 8'(k);
            tick();
            receive_data = 1'b0;
            n_checks++;
            if (ack !== exp_g || rx_data !== (8'h80 + 8'(k)) || err !== 1'b0 || send_data !== 1'b0) begin
                n_fail++;
                $display("FAIL fair_ack[%0d]: ack=%b rx=%h err=%b send=%b required %b/%h/0/0", k, ack, rx_data, err, send_data, exp_g, 8'h80 + 8'(k));
            end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req[1] = 1'b1; req_data[8*1 +: 8] = 8'h5A;
        wait_send(1'b1, n);
        tick();
        receive_data = 1'b1; miso_byte = 8'h77;
        tick();
        receive_data = 1'b0;
        n_checks++;
        if (n != 2 || b_ack !== 4'b0010 || b_rx_data !== 8'h77 || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_first: n=%0d ack=%b rx=%h err=%b required 2/0010/77/0", n, b_ack, b_rx_data, b_err);
        end
        wait_send(1'b1, n);
        n_checks++;
        if (n != 7) begin
            n_fail++;
            $display("FAIL tmo_send: %0d cycles, required 7", n);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (b_ack === '0 && n < 40);
        n_checks++;
        if (n != 16 || b_ack !== 4'b0010 || b_err !== 1'b1 || b_rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL tmo_abort: %0d cycles ack=%b err=%b rx=%h required 16/0010/1/00", n, b_ack, b_err, b_rx_data);
        end
        req = 4'b0100; req_data[8*2 +: 8] = 8'h6B;
        wait_send(1'b1, n);
        n_checks++;
        if (n != 7 || b_grant !== 4'b0100 || b_mosi_byte !== 8'h6B) begin
            n_fail++;
            $display("FAIL tmo_next_send: n=%0d grant=%b mosi=%h required 7/0100/6b", n, b_grant, b_mosi_byte);
        end
        tick();
        receive_data = 1'b1; miso_byte = 8'hC3;
        tick();
        receive_data = 1'b0; req = '0;
        n_checks++;
        if (b_ack !== 4'b0100 || b_rx_data !== 8'hC3 || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_next_done: ack=%b rx=%h err=%b required 0100/c3/0", b_ack, b_rx_data, b_err);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        req[3] = 1'b1; req_data[8*3 +: 8] = 8'h33;
        wait_send(1'b0, n);
        tick(); tick();
        receive_data = 1'b1; miso_byte = 8'h99; core_ready = 1'b0;
        tick();
        receive_data = 1'b0; req = '0;
        n_checks++;
        if (ack !== 4'b1000 || err !== 1'b0 || rx_data !== 8'h99) begin
            n_fail++;
            $display("FAIL simul_done: ack=%b err=%b rx=%h required 1000/0/99", ack, err, rx_data);
        end
    endtask

    // Continues from the DONE cycle left by test_simultaneous, so rx_data starts non-zero.
    task automatic test_abort();
        int n, bad;
        core_ready = 1'b1;
        req[0] = 1'b1; req_data[8*0 +: 8] = 8'h11;
        wait_send(1'b0, n);
        n_checks++;
        if (n != 7 || grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_send: n=%0d grant=%b required 7/0001", n, grant);
        end
        for (int i = 0; i < 5; i++) tick();
        core_ready = 1'b0;
        tick();
        n_checks++;
        if (ack !== 4'b0001 || err !== 1'b1 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_done: ack=%b err=%b rx=%h required 0001/1/00", ack, err, rx_data);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (send_data !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold: %0d sends busy=%b while core not ready, required 0/0", bad, busy);
        end
        core_ready = 1'b1;
        wait_send(1'b0, n);
        n_checks++;
        if (n != 2 || grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_resume: n=%0d grant=%b required 2/0001", n, grant);
        end
    endtask

    task automatic test_tip();
        int n, bad;
        do_reset();
        tip = 1'b1;
        req[1] = 1'b1; req_data[8*1 +: 8] = 8'h4D;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (send_data !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL tip_block: %0d cycles left IDLE while tip high, required 0", bad);
        end
        tip = 1'b0;
        wait_send(1'b0, n);
        n_checks++;
        if (n != 2 || mosi_byte !== 8'h4D) begin
            n_fail++;
            $display("FAIL tip_release: n=%0d mosi=%h required 2/4d", n, mosi_byte);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        req[2] = 1'b1; req_data[8*2 +: 8] = 8'hE7;
        wait_send(1'b0, n);
        tick(); tick();
        n_checks++;
        if (busy !== 1'b1 || grant !== 4'b0100 || mosi_byte !== 8'hE7) begin
            n_fail++;
            $display("FAIL rstmid_pre: busy=%b grant=%b mosi=%h required 1/0100/e7", busy, grant, mosi_byte);
        end
        PRESET = 1'b1;
        #2;
        n_checks++;
        if ({send_data, mosi_byte, grant, ack, rx_data, err, busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b required 0", {send_data, mosi_byte, grant, ack, rx_data, err, busy});
        end
        req = 4'b1010; req_data = {8'h23, 8'h00, 8'h21, 8'h00};
        #1;
        PRESET = 1'b0;
        wait_send(1'b0, n);
        n_checks++;
        if (n != 2 || grant !== 4'b0010 || mosi_byte !== 8'h21) begin
            n_fail++;
            $display("FAIL rstmid_ptr: n=%0d grant=%b mosi=%h required 2/0010/21", n, grant, mosi_byte);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_simultaneous();
        test_abort();
        test_tip();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
